// File: rtl/ddr_util_pkg.sv
// Shared definitions for the DDR utilisation monitor.
// Holds the per-channel event indices and the saturating/wrapping counter step helpers.
// The helpers work on a MAX_W-wide value so that one function serves every CNT_W.
package ddr_util_pkg;

    localparam int unsigned EV_RD    = 0;
    localparam int unsigned EV_WR    = 1;
    localparam int unsigned EV_IDLE  = 2;
    localparam int unsigned EV_STALL = 3;
    localparam int unsigned NUM_EV   = 4;

    // Widest counter supported; callers zero-extend into and truncate out of it.
    localparam int unsigned MAX_W = 48;

    // All-ones value for a counter of width w, held in MAX_W bits.
    function automatic logic [MAX_W-1:0] cnt_ones(input int unsigned w);
        cnt_ones = (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // Next counter value for a 0/1 increment; saturates at all-ones or wraps to 0.
    function automatic logic [MAX_W-1:0] cnt_next(input logic [MAX_W-1:0] cur,
                                                  input logic             inc,
                                                  input int unsigned      w,
                                                  input logic             sat_en);
        logic [MAX_W-1:0] ones;
        ones = cnt_ones(w);
        if (!inc) begin
            cnt_next = cur;
        end else if (cur == ones) begin
            cnt_next = sat_en ? ones : '0;
        end else begin
            cnt_next = cur + MAX_W'(inc);
        end
    endfunction

    // High when this step reaches all-ones (saturating) or rolls over (wrapping).
    function automatic logic cnt_hit(input logic [MAX_W-1:0] cur,
                                     input logic             inc,
                                     input int unsigned      w,
                                     input logic             sat_en);
        logic [MAX_W-1:0] ones;
        ones = cnt_ones(w);
        if (!inc) begin
            cnt_hit = 1'b0;
        end else if (cur == ones) begin
            cnt_hit = 1'b1;
        end else begin
            cnt_hit = sat_en && ((cur + MAX_W'(1)) == ones);
        end
    endfunction

endpackage

// File: rtl/ddr_util_ch_cnt.sv
// One channel's live utilisation counters (read, write, idle, stall) plus its sticky sat bit.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   rdy, rd, wr     controller ready / read request / write request of this channel
//   snap            snapshot edge: counters restart with the current cycle's event
//   clr             software clear: counters load 0, current event discarded
//   cnt             live counts indexed by EV_*
//   sat             sticky: a counter hit all-ones (or wrapped) since the last restart
module ddr_util_ch_cnt
    import ddr_util_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter logic        SAT_EN = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rdy,
    input  logic                             rd,
    input  logic                             wr,
    input  logic                             snap,
    input  logic                             clr,
    output logic [NUM_EV-1:0][CNT_W-1:0]     cnt,
    output logic                             sat
);

    logic [NUM_EV-1:0]              ev_c;
    logic [NUM_EV-1:0][CNT_W-1:0]   nxt_c;
    logic [NUM_EV-1:0]              hit_c;

    // Cycle classification; rd and wr may both count in the same cycle.
    always_comb begin
        ev_c           = '0;
        ev_c[EV_RD]    = rdy & rd;
        ev_c[EV_WR]    = rdy & wr;
        ev_c[EV_IDLE]  = rdy & ~rd & ~wr;
        ev_c[EV_STALL] = ~rdy & (rd | wr);
    end

    // Next values and saturation/rollover hits for each counter.
    always_comb begin
        nxt_c = '0;
        hit_c = '0;
        for (int unsigned e = 0; e < NUM_EV; e++) begin
            nxt_c[e] = CNT_W'(cnt_next(MAX_W'(cnt[e]), ev_c[e], CNT_W, SAT_EN));
            hit_c[e] = cnt_hit(MAX_W'(cnt[e]), ev_c[e], CNT_W, SAT_EN);
        end
    end

    // Live counter registers; clear wins over snapshot restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (snap) begin
            for (int unsigned e = 0; e < NUM_EV; e++) begin
                cnt[e] <= CNT_W'(ev_c[e]);
            end
            sat <= 1'b0;
        end else begin
            cnt <= nxt_c;
            sat <= sat | (|hit_c);
        end
    end

endmodule

// File: rtl/ddr_util_monitor.sv
// Multi-channel DDR utilisation monitor: per-channel busy/idle/stall counters over a window
// closed by the rising edge of net_finish, snapshotted without losing any cycle.
// Ports:
//   ddr_usr_clk, sys_rst_n         clock, synchronous active-low reset
//   net_finish                     level; its rising edge closes the window
//   sw_clr                         clears live counters, outputs untouched
//   ddr_rdy/ddr_rdreq/ddr_wrreq    per-channel controller status
//   rd_cnt/wr_cnt/idle_cnt/stall_cnt  snapshot counts, ch0 in the LSBs
//   win_cnt                        snapshot of window length in cycles
//   sat_flag                       snapshot of per-channel sticky saturation
//   snap_valid                     one-cycle pulse with each new snapshot
module ddr_util_monitor
    import ddr_util_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned SAT_EN = 1
) (
    input  logic                      ddr_usr_clk,
    input  logic                      sys_rst_n,
    input  logic                      net_finish,
    input  logic                      sw_clr,
    input  logic [NUM_CH-1:0]         ddr_rdy,
    input  logic [NUM_CH-1:0]         ddr_rdreq,
    input  logic [NUM_CH-1:0]         ddr_wrreq,
    output logic [NUM_CH*CNT_W-1:0]   rd_cnt,
    output logic [NUM_CH*CNT_W-1:0]   wr_cnt,
    output logic [NUM_CH*CNT_W-1:0]   idle_cnt,
    output logic [NUM_CH*CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]          win_cnt,
    output logic [NUM_CH-1:0]         sat_flag,
    output logic                      snap_valid
);

    localparam logic SAT_ON = (SAT_EN != 0);

    logic                                         fin_d1;
    logic                                         fin_rise_c;
    logic                                         snap_req;
    logic [CNT_W-1:0]                             win_live;
    logic [NUM_CH-1:0][NUM_EV-1:0][CNT_W-1:0]     live;
    logic [NUM_CH-1:0]                            sticky;

    assign fin_rise_c = net_finish & ~fin_d1;

    // Per-channel live counters.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        ddr_util_ch_cnt #(
            .CNT_W  (CNT_W),
            .SAT_EN (SAT_ON)
        ) u_ch_cnt (
            .clk   (ddr_usr_clk),
            .rst_n (sys_rst_n),
            .rdy   (ddr_rdy[ch]),
            .rd    (ddr_rdreq[ch]),
            .wr    (ddr_wrreq[ch]),
            .snap  (snap_req),
            .clr   (sw_clr),
            .cnt   (live[ch]),
            .sat   (sticky[ch])
        );
    end

    // Edge detect, window counter and snapshot registers.
    always_ff @(posedge ddr_usr_clk) begin
        if (!sys_rst_n) begin
            fin_d1     <= 1'b0;
            snap_req   <= 1'b0;
            snap_valid <= 1'b0;
            win_live   <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            idle_cnt   <= '0;
            stall_cnt  <= '0;
            win_cnt    <= '0;
            sat_flag   <= '0;
        end else begin
            fin_d1     <= net_finish;
            snap_req   <= fin_rise_c;
            snap_valid <= snap_req;

            // The snapshot cycle itself opens the next window, so the restart value is 1.
            if (sw_clr) begin
                win_live <= '0;
            end else if (snap_req) begin
                win_live <= CNT_W'(1);
            end else begin
                win_live <= CNT_W'(cnt_next(MAX_W'(win_live), 1'b1, CNT_W, SAT_ON));
            end

            if (snap_req) begin
                for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                    rd_cnt[ch*CNT_W +: CNT_W]    <= live[ch][EV_RD];
                    wr_cnt[ch*CNT_W +: CNT_W]    <= live[ch][EV_WR];
                    idle_cnt[ch*CNT_W +: CNT_W]  <= live[ch][EV_IDLE];
                    stall_cnt[ch*CNT_W +: CNT_W] <= live[ch][EV_STALL];
                end
                win_cnt  <= win_live;
                sat_flag <= sticky;
            end
        end
    end

endmodule

// File: tb/tb_ddr_util_monitor.sv
// Directed bench for ddr_util_monitor: a 4-channel 32-bit instance plus two
// 1-channel 8-bit instances (saturating and wrapping) sharing the same stimulus.
module tb_ddr_util_monitor;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned SW  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              net_finish;
    logic              sw_clr;
    logic [NCH-1:0]    rdy;
    logic [NCH-1:0]    rdreq;
    logic [NCH-1:0]    wrreq;

    logic [NCH*W-1:0]  rd_cnt, wr_cnt, idle_cnt, stall_cnt;
    logic [W-1:0]      win_cnt;
    logic [NCH-1:0]    sat_flag;
    logic              snap_valid;

    logic [SW-1:0]     s_rd, s_wr, s_idle, s_stall, s_win;
    logic [0:0]        s_sat;
    logic              s_sv;
    logic [SW-1:0]     w_rd, w_wr, w_idle, w_stall, w_win;
    logic [0:0]        w_sat;
    logic              w_sv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr_util_monitor #(.NUM_CH(NCH), .CNT_W(W), .SAT_EN(1)) dut (
        .ddr_usr_clk (clk),
        .sys_rst_n   (rst_n),
        .net_finish  (net_finish),
        .sw_clr      (sw_clr),
        .ddr_rdy     (rdy),
        .ddr_rdreq   (rdreq),
        .ddr_wrreq   (wrreq),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt),
        .idle_cnt    (idle_cnt),
        .stall_cnt   (stall_cnt),
        .win_cnt     (win_cnt),
        .sat_flag    (sat_flag),
        .snap_valid  (snap_valid)
    );

    ddr_util_monitor #(.NUM_CH(1), .CNT_W(SW), .SAT_EN(1)) dut_sat (
        .ddr_usr_clk (clk),
        .sys_rst_n   (rst_n),
        .net_finish  (net_finish),
        .sw_clr      (sw_clr),
        .ddr_rdy     (rdy[0:0]),
        .ddr_rdreq   (rdreq[0:0]),
        .ddr_wrreq   (wrreq[0:0]),
        .rd_cnt      (s_rd),
        .wr_cnt      (s_wr),
        .idle_cnt    (s_idle),
        .stall_cnt   (s_stall),
        .win_cnt     (s_win),
        .sat_flag    (s_sat),
        .snap_valid  (s_sv)
    );

    ddr_util_monitor #(.NUM_CH(1), .CNT_W(SW), .SAT_EN(0)) dut_wrap (
        .ddr_usr_clk (clk),
        .sys_rst_n   (rst_n),
        .net_finish  (net_finish),
        .sw_clr      (sw_clr),
        .ddr_rdy     (rdy[0:0]),
        .ddr_rdreq   (rdreq[0:0]),
        .ddr_wrreq   (wrreq[0:0]),
        .rd_cnt      (w_rd),
        .wr_cnt      (w_wr),
        .idle_cnt    (w_idle),
        .stall_cnt   (w_stall),
        .win_cnt     (w_win),
        .sat_flag    (w_sat),
        .snap_valid  (w_sv)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; leaves time 1 unit after the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_cycle();
        sw_clr = 1'b1;
        cyc(1);
        sw_clr = 1'b0;
    endtask

    // Rising edge of net_finish; snapshot lands after the second edge.
    task automatic close_window();
        net_finish = 1'b1;
        cyc(1);
        net_finish = 1'b0;
        cyc(1);
    endtask

    function automatic logic [W-1:0] sl(input logic [NCH*W-1:0] v, input int ch);
        return v[ch*W +: W];
    endfunction

    int          pulses;
    logic [W-1:0] w1;

    initial begin
        rst_n = 1'b0; net_finish = 1'b0; sw_clr = 1'b0;
        rdy = '0; rdreq = '0; wrreq = '0;
        cyc(2);
        check("rst_counts", 64'(|{rd_cnt, wr_cnt, idle_cnt, stall_cnt}), 64'd0);
        check("rst_win", 64'(win_cnt), 64'd0);
        check("rst_sat", 64'(sat_flag), 64'd0);
        check("rst_sv", 64'(snap_valid), 64'd0);

        // Window 1: ch0 reading continuously.
        rst_n = 1'b1; rdy = 4'b0001; rdreq = 4'b0001;
        cyc(100);
        close_window();
        check("t1_sv", 64'(snap_valid), 64'd1);
        check("t1_rd0", 64'(sl(rd_cnt, 0)), 64'd101);
        check("t1_idle0", 64'(sl(idle_cnt, 0)), 64'd0);
        check("t1_win", 64'(win_cnt), 64'd101);
        check("t1_sat", 64'(sat_flag), 64'd0);
        cyc(1);
        check("t1_sv_drop", 64'(snap_valid), 64'd0);

        // ch1 read+write together, then idle.
        rdy = '0; rdreq = '0; wrreq = '0;
        clr_cycle();
        rdy = 4'b0010; rdreq = 4'b0010; wrreq = 4'b0010;
        cyc(10);
        rdreq = '0; wrreq = '0;
        cyc(4);
        close_window();
        check("t2_rd1", 64'(sl(rd_cnt, 1)), 64'd10);
        check("t2_wr1", 64'(sl(wr_cnt, 1)), 64'd10);
        check("t2_idle1", 64'(sl(idle_cnt, 1)), 64'd5);
        check("t2_stall1", 64'(sl(stall_cnt, 1)), 64'd0);
        check("t2_win", 64'(win_cnt), 64'd15);
        check("t2_rd0", 64'(sl(rd_cnt, 0)), 64'd0);

        // ch2 stalled writes, then accepted writes.
        rdy = '0; rdreq = '0; wrreq = '0;
        clr_cycle();
        wrreq = 4'b0100;
        cyc(7);
        rdy = 4'b0100;
        cyc(2);
        close_window();
        check("t3_stall2", 64'(sl(stall_cnt, 2)), 64'd7);
        check("t3_wr2", 64'(sl(wr_cnt, 2)), 64'd3);
        check("t3_idle2", 64'(sl(idle_cnt, 2)), 64'd0);
        check("t3_win", 64'(win_cnt), 64'd10);

        // Back-to-back windows: no cycle lost across the snapshot.
        rdy = '0; wrreq = '0;
        clr_cycle();
        cyc(49);
        close_window();
        check("b2b_sv1", 64'(snap_valid), 64'd1);
        check("b2b_win1", 64'(win_cnt), 64'd50);
        w1 = win_cnt;
        cyc(28);
        close_window();
        check("b2b_sv2", 64'(snap_valid), 64'd1);
        check("b2b_win2", 64'(win_cnt), 64'd30);
        check("b2b_sum", 64'(w1 + win_cnt), 64'd80);

        // sw_clr part-way through a window.
        clr_cycle();
        cyc(19);
        clr_cycle();
        cyc(19);
        close_window();
        check("clr_mid_win", 64'(win_cnt), 64'd20);

        // sw_clr on the snapshot edge: snapshot kept, live restarts at 0.
        clr_cycle();
        cyc(9);
        net_finish = 1'b1;
        cyc(1);
        net_finish = 1'b0;
        sw_clr = 1'b1;
        cyc(1);
        sw_clr = 1'b0;
        check("clr_snap_sv", 64'(snap_valid), 64'd1);
        check("clr_snap_win", 64'(win_cnt), 64'd10);
        cyc(5);
        close_window();
        check("clr_snap_next", 64'(win_cnt), 64'd6);

        // net_finish held high: one snapshot only.
        pulses = 0;
        net_finish = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (snap_valid) pulses++;
        end
        net_finish = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            if (snap_valid) pulses++;
        end
        check("held_pulses", 64'(pulses), 64'd1);

        // Reset with a snapshot pending.
        rdy = 4'b0001; rdreq = 4'b0001;
        cyc(5);
        net_finish = 1'b1;
        cyc(1);
        rst_n = 1'b0; net_finish = 1'b0;
        cyc(1);
        check("mrst_counts", 64'(|{rd_cnt, wr_cnt, idle_cnt, stall_cnt}), 64'd0);
        check("mrst_win", 64'(win_cnt), 64'd0);
        check("mrst_sv", 64'(snap_valid), 64'd0);
        check("mrst_small", 64'({s_rd, s_win, w_rd, w_win}), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("mrst_no_sv", 64'(snap_valid), 64'd0);
        end
        close_window();
        check("mrst_sv_after", 64'(snap_valid), 64'd1);
        check("mrst_win_after", 64'(win_cnt), 64'd4);
        check("mrst_rd0_after", 64'(sl(rd_cnt, 0)), 64'd4);

        // 300 read cycles into 8-bit counters.
        clr_cycle();
        cyc(299);
        close_window();
        check("sat_rd", 64'(s_rd), 64'd255);
        check("sat_flag", 64'(s_sat), 64'd1);
        check("sat_win", 64'(s_win), 64'd255);
        check("wrap_rd", 64'(w_rd), 64'd44);
        check("wrap_flag", 64'(w_sat), 64'd1);
        check("wrap_win", 64'(w_win), 64'd44);
        check("wide_rd0", 64'(sl(rd_cnt, 0)), 64'd300);
        check("wide_sat", 64'(sat_flag), 64'd0);

        // Sticky bits restart; live counters kept the snapshot-cycle event.
        cyc(3);
        close_window();
        check("sat_rd_next", 64'(s_rd), 64'd5);
        check("sat_flag_next", 64'(s_sat), 64'd0);
        check("wrap_rd_next", 64'(w_rd), 64'd5);
        check("wrap_flag_next", 64'(w_sat), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_util_monitor.md
Name: ddr_util_monitor

Overview:
Parametrised multi-channel DDR utilisation monitor, the successor of the single-port utilisation counter. It sits on the DDR user clock beside the DDR controller arbiter ports. Per channel it counts read-busy, write-busy, idle and stall cycles over one network-inference window, using saturating counters. On each net_finish rising edge it snapshots all counters to stable outputs, with no lost cycles between windows, and raises snap_valid.

Parameters:
NUM_CH, 4, number of DDR user ports monitored (1..8)
CNT_W, 32, counter width (8..48)
SAT_EN, 1, 1 = counters saturate at all-ones; 0 = counters wrap

Ports:
ddr_usr_clk  in  1  DDR user clock; the only clock
sys_rst_n  in  1  reset, synchronous, active-low
net_finish  in  1  network-done level; its rising edge closes the window
sw_clr  in  1  software clear of live counters, no snapshot taken
ddr_rdy  in  NUM_CH  per-channel controller ready
ddr_rdreq  in  NUM_CH  per-channel read request
ddr_wrreq  in  NUM_CH  per-channel write request
rd_cnt  out  NUM_CH*CNT_W  snapshot of read-busy cycles; ch0 in the LSBs
wr_cnt  out  NUM_CH*CNT_W  snapshot of write-busy cycles
idle_cnt  out  NUM_CH*CNT_W  snapshot of idle cycles
stall_cnt  out  NUM_CH*CNT_W  snapshot of stall cycles
win_cnt  out  CNT_W  snapshot of total window cycles
sat_flag  out  NUM_CH  snapshot; 1 = a counter of that channel hit all-ones in the window
snap_valid  out  1  one-cycle pulse when new snapshot outputs are valid

Behaviour:
- Reset: synchronous. While sys_rst_n=0 at a clock edge, all live counters, all snapshot outputs, sat_flag, snap_valid and the edge register go to 0. Reset mid-window discards the window.
- Per-channel events, evaluated each cycle with rdy/rd/wr of that channel:
  - rdy & rd -> rd +1
  - rdy & wr -> wr +1; rd and wr both high -> both +1
  - rdy & !rd & !wr -> idle +1
  - !rdy & (rd|wr) -> stall +1
  - !rdy & !rd & !wr -> no count
- win counter: +1 every cycle.
- Edge detect: fin_d1 <= net_finish; fin_rise = net_finish & ~fin_d1. snap_req register <= fin_rise. Snapshot occurs at the edge where snap_req=1, i.e. 2 edges after net_finish is first sampled high.
- Snapshot edge:
  - Outputs <= live values, excluding the current cycle's event.
  - Live counters load the current cycle's increment (0 or 1), so no cycle is lost.
  - sat_flag <= live sticky sat bits; sticky bits then restart at 0.
  - snap_valid=1 on the following cycle only.
  - Outputs hold between snapshots.
- net_finish held high: only one snapshot. A new edge requires net_finish to return to 0 first.
- sw_clr=1: live counters and sticky sat bits load 0, and the current event is discarded. Outputs are unaffected.
- sw_clr coincident with snap_req: the snapshot is still taken, and live counters load 0.
- Saturation, SAT_EN=1: a counter at all-ones stays there, and the channel's sticky sat bit is set when any counter reaches all-ones. win counter saturates likewise but sets no flag.
- Wrap, SAT_EN=0: counters roll over to 0, and sticky sat is set on rollover.
- Arithmetic: unsigned, CNT_W bits. The increment is zero-extended 1 bit. No signed logic.

Decomposition:
- Package ddr_util_pkg holds:
  - event-index constants EV_RD=0, EV_WR=1, EV_IDLE=2, EV_STALL=3, NUM_EV=4
  - a helper function for the saturating/wrapping increment, parametrised by SAT_EN
- Sub-module ddr_util_ch_cnt, instantiated NUM_CH times by a generate loop:
  - holds one channel's four live counters and its sticky sat bit
  - inputs: rdy, rd, wr, snap, clr
  - outputs: live counts and sticky bit
- The top holds edge detect, win counter, snapshot registers and snap_valid.

Test Plan:
- Reset then 100 cycles with ch0 rdy=1, rd=1 throughout; net_finish rises at cycle 100 -> snap_valid pulses once; ch0 rd_cnt=101, idle=0, win_cnt=101, sat_flag=0.
- ch1 rdy=1 with rd=wr=1 for 10 cycles, then 5 idle cycles, then a window close -> ch1 rd=10, wr=10, idle=5, stall=0.
- ch2 rdy=0 with wrreq=1 for 7 cycles, then rdy=1 with wr=1 for 3 cycles -> ch2 stall=7, wr=3.
- Back-to-back windows: net_finish pulses at cycles 50 and 80 -> second snapshot win_cnt=30; sum of win_cnt across both snapshots equals elapsed cycles.
- CNT_W=8, SAT_EN=1, ch0 rd held 300 cycles -> rd_cnt=255, sat_flag[0]=1. Same stimulus with SAT_EN=0 -> rd_cnt=44, sat_flag[0]=1.
- Edge cases: sw_clr at cycle 20 of a 40-cycle window -> win_cnt=20. sys_rst_n=0 mid-window -> all outputs 0, and no snap_valid until the next edge. net_finish held high for 10 cycles -> exactly one snap_valid.
